// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
// Control bundle ordering matches the register chain from PC down to MEM_WB.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_HALT     = 2'd2
  } pipe_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;
  localparam logic [4:0]  REG_X0    = 5'd0;

  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic id_ex_en;
    logic ex_mem_en;
    logic mem_wb_en;
    logic if_id_flush;
    logic id_ex_flush;
  } pipe_ctrl_t;

  localparam pipe_ctrl_t CTRL_OFF      = '{default: 1'b0};
  localparam pipe_ctrl_t CTRL_NORMAL   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  localparam pipe_ctrl_t CTRL_FLUSH    = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
  localparam pipe_ctrl_t CTRL_LOAD_USE = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

endpackage

// File: rtl/pipeline_ctrl_load_use_detect.sv
// Combinational load-use hazard comparator between the ID and EX stages.
module load_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic       ex_is_load_i,
  input  logic       ex_rd_wren_i,
  input  logic [4:0] ex_rd_addr_i,
  input  logic [4:0] id_rs1_addr_i,
  input  logic [4:0] id_rs2_addr_i,
  input  logic       id_is_rs1_i,
  input  logic       id_is_rs2_i,
  output logic       load_use_o
);

  logic rs1_hit;
  logic rs2_hit;

  // x0 never carries a real dependency, so a load targeting it cannot stall.
  always_comb begin
    rs1_hit    = id_is_rs1_i && (id_rs1_addr_i == ex_rd_addr_i);
    rs2_hit    = id_is_rs2_i && (id_rs2_addr_i == ex_rd_addr_i);
    load_use_o = ex_is_load_i && ex_rd_wren_i && (ex_rd_addr_i != REG_X0)
                 && (rs1_hit || rs2_hit);
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush controller for the 5-stage pipeline with memory-wait watchdog
// and stall/flush performance counters.
module pipeline_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [4:0]  id_rs1_addr_i,
  input  logic [4:0]  id_rs2_addr_i,
  input  logic        id_is_rs1_i,
  input  logic        id_is_rs2_i,
  input  logic [4:0]  ex_rd_addr_i,
  input  logic        ex_rd_wren_i,
  input  logic        ex_is_load_i,
  input  logic        ex_mispredict_i,
  input  logic        mem_req_i,
  input  logic        mem_ready_i,
  output logic        pc_en_o,
  output logic        if_id_en_o,
  output logic        id_ex_en_o,
  output logic        ex_mem_en_o,
  output logic        mem_wb_en_o,
  output logic        if_id_flush_o,
  output logic        id_ex_flush_o,
  output logic        halt_o,
  output logic [1:0]  state_o,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] flush_cnt_o
);

  localparam logic [15:0] WD_LIMIT = 16'(MEM_TIMEOUT - 1);

  pipe_state_e state_q, state_d;
  logic [15:0] wd_q, wd_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  pipe_ctrl_t ctrl;
  logic       halt;
  logic       load_use;
  logic       mem_block;

  load_use_detect u_load_use_detect (
    .ex_is_load_i  (ex_is_load_i),
    .ex_rd_wren_i  (ex_rd_wren_i),
    .ex_rd_addr_i  (ex_rd_addr_i),
    .id_rs1_addr_i (id_rs1_addr_i),
    .id_rs2_addr_i (id_rs2_addr_i),
    .id_is_rs1_i   (id_is_rs1_i),
    .id_is_rs2_i   (id_is_rs2_i),
    .load_use_o    (load_use)
  );

  assign mem_block = mem_req_i && !mem_ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_RUN;
      wd_q        <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wd_q        <= wd_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // The entering cycle is already a blocked cycle, so the watchdog starts at 1.
  always_comb begin
    state_d = state_q;
    wd_d    = wd_q;
    case (state_q)
      ST_RUN: begin
        if (mem_block) begin
          state_d = ST_MEM_WAIT;
          wd_d    = 16'd1;
        end
      end
      ST_MEM_WAIT: begin
        if (mem_block) begin
          if (wd_q == WD_LIMIT) begin
            state_d = ST_HALT;
          end else begin
            wd_d = wd_q + 16'd1;
          end
        end else begin
          state_d = ST_RUN;
          wd_d    = '0;
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_RUN;
        wd_d    = '0;
      end
    endcase
  end

  always_comb begin
    ctrl = CTRL_OFF;
    halt = 1'b0;
    if (!rst_i) begin
      case (state_q)
        ST_RUN, ST_MEM_WAIT: begin
          if (mem_block) begin
            ctrl = CTRL_OFF;
          end else if (ex_mispredict_i) begin
            ctrl = CTRL_FLUSH;
          end else if (load_use) begin
            ctrl = CTRL_LOAD_USE;
          end else begin
            ctrl = CTRL_NORMAL;
          end
        end
        ST_HALT: begin
          halt = 1'b1;
        end
        default: begin
          ctrl = CTRL_OFF;
        end
      endcase
    end
  end

  // Stalls and flushes are only counted while the pipeline is live.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!rst_i && (state_q != ST_HALT)) begin
      if (!ctrl.pc_en) begin
        stall_cnt_d = stall_cnt_q + 32'd1;
      end
      if (ctrl.if_id_flush) begin
        flush_cnt_d = flush_cnt_q + 32'd1;
      end
    end
  end

  assign pc_en_o       = ctrl.pc_en;
  assign if_id_en_o    = ctrl.if_id_en;
  assign id_ex_en_o    = ctrl.id_ex_en;
  assign ex_mem_en_o   = ctrl.ex_mem_en;
  assign mem_wb_en_o   = ctrl.mem_wb_en;
  assign if_id_flush_o = ctrl.if_id_flush;
  assign id_ex_flush_o = ctrl.id_ex_flush;
  assign halt_o        = halt;
  assign state_o       = state_q;
  assign stall_cnt_o   = stall_cnt_q;
  assign flush_cnt_o   = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: single-cycle hazard table followed by
// hand-written memory-wait, timeout and reset sequences.
module tb_pipeline_ctrl;

  logic        clk;
  logic        rst;
  logic [4:0]  idRs1;
  logic [4:0]  idRs2;
  logic        idIsRs1;
  logic        idIsRs2;
  logic [4:0]  exRd;
  logic        exWren;
  logic        exLoad;
  logic        exMisp;
  logic        memReq;
  logic        memRdy;
  logic        pcEn, ifIdEn, idExEn, exMemEn, memWbEn;
  logic        ifIdFlush, idExFlush;
  logic        halt;
  logic [1:0]  state;
  logic [31:0] stallCnt;
  logic [31:0] flushCnt;

  int checks = 0;
  int passes = 0;
  int expStall = 0;
  int expFlush = 0;

  localparam logic [6:0] C_NORMAL = 7'b11111_00;
  localparam logic [6:0] C_LU     = 7'b00111_01;
  localparam logic [6:0] C_FLUSH  = 7'b11111_11;
  localparam logic [6:0] C_OFF    = 7'b00000_00;

  typedef struct {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       isRs1;
    logic       isRs2;
    logic [4:0] rd;
    logic       wren;
    logic       load;
    logic       misp;
    logic       req;
    logic       rdy;
    logic [6:0] expCtrl;
  } vec_t;

  vec_t vecs[10];

  pipeline_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .id_rs1_addr_i   (idRs1),
    .id_rs2_addr_i   (idRs2),
    .id_is_rs1_i     (idIsRs1),
    .id_is_rs2_i     (idIsRs2),
    .ex_rd_addr_i    (exRd),
    .ex_rd_wren_i    (exWren),
    .ex_is_load_i    (exLoad),
    .ex_mispredict_i (exMisp),
    .mem_req_i       (memReq),
    .mem_ready_i     (memRdy),
    .pc_en_o         (pcEn),
    .if_id_en_o      (ifIdEn),
    .id_ex_en_o      (idExEn),
    .ex_mem_en_o     (exMemEn),
    .mem_wb_en_o     (memWbEn),
    .if_id_flush_o   (ifIdFlush),
    .id_ex_flush_o   (idExFlush),
    .halt_o          (halt),
    .state_o         (state),
    .stall_cnt_o     (stallCnt),
    .flush_cnt_o     (flushCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mkVec(input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic isRs1, input logic isRs2,
                                 input logic [4:0] rd, input logic wren,
                                 input logic load, input logic misp,
                                 input logic req, input logic rdy,
                                 input logic [6:0] expCtrl);
    vec_t v;
    v.rs1 = rs1; v.rs2 = rs2; v.isRs1 = isRs1; v.isRs2 = isRs2;
    v.rd = rd; v.wren = wren; v.load = load; v.misp = misp;
    v.req = req; v.rdy = rdy; v.expCtrl = expCtrl;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    idRs1 = v.rs1; idRs2 = v.rs2; idIsRs1 = v.isRs1; idIsRs2 = v.isRs2;
    exRd = v.rd; exWren = v.wren; exLoad = v.load; exMisp = v.misp;
    memReq = v.req; memRdy = v.rdy;
  endtask

  task automatic setMem(input logic req, input logic rdy, input logic misp);
    applyStimulus(mkVec(5'd1, 5'd2, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, misp, req, rdy, C_OFF));
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [6:0] ctrlNow();
    return {pcEn, ifIdEn, idExEn, exMemEn, memWbEn, ifIdFlush, idExFlush};
  endfunction

  task automatic midCycle();
    @(negedge clk);
  endtask

  task automatic afterEdge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0] = mkVec(5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, C_NORMAL);
    vecs[1] = mkVec(5'd1, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, C_LU);
    vecs[2] = mkVec(5'd1, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, C_NORMAL);
    vecs[3] = mkVec(5'd7, 5'd2, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, C_LU);
    vecs[4] = mkVec(5'd7, 5'd2, 1'b0, 1'b1, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, C_NORMAL);
    vecs[5] = mkVec(5'd1, 5'd5, 1'b1, 1'b1, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, C_NORMAL);
    vecs[6] = mkVec(5'd1, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, C_NORMAL);
    vecs[7] = mkVec(5'd1, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, C_FLUSH);
    vecs[8] = mkVec(5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, C_FLUSH);
    vecs[9] = mkVec(5'd4, 5'd2, 1'b1, 1'b1, 5'd4, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, C_LU);

    rst = 1'b1;
    setMem(1'b0, 1'b0, 1'b0);
    midCycle();
    checkOutput("reset_ctrl", {25'd0, ctrlNow()}, {25'd0, C_OFF});
    checkOutput("reset_halt", {31'd0, halt}, 32'd0);
    afterEdge();
    rst = 1'b0;
    checkOutput("reset_state", {30'd0, state}, 32'd0);
    checkOutput("reset_stall", stallCnt, 32'd0);
    checkOutput("reset_flush", flushCnt, 32'd0);

    // Single-cycle hazard table, all applied in RUN.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i]);
      midCycle();
      checkOutput($sformatf("vec%0d_ctrl", i), {25'd0, ctrlNow()}, {25'd0, vecs[i].expCtrl});
      if (!vecs[i].expCtrl[6]) expStall++;
      if (vecs[i].expCtrl[1]) expFlush++;
      afterEdge();
      checkOutput($sformatf("vec%0d_state", i), {30'd0, state}, 32'd0);
      checkOutput($sformatf("vec%0d_stall", i), stallCnt, 32'(expStall));
      checkOutput($sformatf("vec%0d_flush", i), flushCnt, 32'(expFlush));
    end

    // Three blocked cycles, then ready.
    for (int i = 0; i < 3; i++) begin
      setMem(1'b1, 1'b0, 1'b0);
      midCycle();
      checkOutput($sformatf("wait%0d_ctrl", i), {25'd0, ctrlNow()}, {25'd0, C_OFF});
      afterEdge();
      checkOutput($sformatf("wait%0d_state", i), {30'd0, state}, 32'd1);
    end
    expStall += 3;
    setMem(1'b1, 1'b1, 1'b0);
    midCycle();
    checkOutput("wait_ready_ctrl", {25'd0, ctrlNow()}, {25'd0, C_NORMAL});
    afterEdge();
    checkOutput("wait_exit_state", {30'd0, state}, 32'd0);
    checkOutput("wait_stall", stallCnt, 32'(expStall));

    // Mispredict held through a two-cycle wait, from a clean reset.
    rst = 1'b1;
    afterEdge();
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      setMem(1'b1, 1'b0, 1'b1);
      midCycle();
      checkOutput($sformatf("mwait%0d_ctrl", i), {25'd0, ctrlNow()}, {25'd0, C_OFF});
      afterEdge();
    end
    setMem(1'b1, 1'b1, 1'b1);
    midCycle();
    checkOutput("mwait_ready_ctrl", {25'd0, ctrlNow()}, {25'd0, C_FLUSH});
    afterEdge();
    checkOutput("mwait_flush", flushCnt, 32'd1);
    checkOutput("mwait_stall", stallCnt, 32'd2);
    checkOutput("mwait_state", {30'd0, state}, 32'd0);

    // Reset asserted in the second cycle of a wait.
    rst = 1'b1;
    afterEdge();
    rst = 1'b0;
    setMem(1'b1, 1'b0, 1'b0);
    afterEdge();
    checkOutput("rmid_enter_state", {30'd0, state}, 32'd1);
    rst = 1'b1;
    midCycle();
    checkOutput("rmid_ctrl", {25'd0, ctrlNow()}, {25'd0, C_OFF});
    afterEdge();
    rst = 1'b0;
    checkOutput("rmid_state", {30'd0, state}, 32'd0);
    checkOutput("rmid_stall", stallCnt, 32'd0);

    // Watchdog from fresh: HALT after exactly four blocked cycles.
    for (int i = 1; i <= 4; i++) begin
      afterEdge();
      checkOutput($sformatf("wd%0d_state", i), {30'd0, state}, (i == 4) ? 32'd2 : 32'd1);
    end
    midCycle();
    checkOutput("halt_flag", {31'd0, halt}, 32'd1);
    checkOutput("halt_ctrl", {25'd0, ctrlNow()}, {25'd0, C_OFF});
    checkOutput("halt_stall", stallCnt, 32'd4);
    setMem(1'b1, 1'b1, 1'b1);
    afterEdge();
    afterEdge();
    checkOutput("halt_sticky_state", {30'd0, state}, 32'd2);
    checkOutput("halt_sticky_stall", stallCnt, 32'd4);
    checkOutput("halt_sticky_flush", flushCnt, 32'd0);
    rst = 1'b1;
    midCycle();
    checkOutput("halt_rst_flag", {31'd0, halt}, 32'd0);
    afterEdge();
    rst = 1'b0;
    setMem(1'b0, 1'b0, 1'b0);
    checkOutput("halt_rst_state", {30'd0, state}, 32'd0);
    checkOutput("halt_rst_stall", stallCnt, 32'd0);
    midCycle();
    checkOutput("halt_rst_halt", {31'd0, halt}, 32'd0);
    checkOutput("halt_rst_ctrl", {25'd0, ctrlNow()}, {25'd0, C_NORMAL});

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
